// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter for the shared register-file write port, with a busy scoreboard.
// Optional feature macro: WB_BYPASS_EN (forwards the in-flight write in the cycle wb_rd_we=1).
module regfile_wb_arbiter #(
  parameter int NUM_REQ = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*5-1:0]   req_rd,
  input  logic [NUM_REQ*32-1:0]  req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic                   rsv_valid,
  input  logic [4:0]             rsv_rd,
  output logic                   rsv_ready,
  input  logic                   sb_clear,
  input  logic [4:0]             q_rs1,
  input  logic [4:0]             q_rs2,
  output logic                   rs1_hazard,
  output logic                   rs2_hazard,
  output logic                   rs1_fwd_valid,
  output logic [31:0]            rs1_fwd_data,
  output logic                   rs2_fwd_valid,
  output logic [31:0]            rs2_fwd_data,
  output logic [4:0]             wb_rd_index,
  output logic [31:0]            wb_rd_data,
  output logic                   wb_rd_we
);

  localparam int PW = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

  logic [31:0]        busy_r;
  logic [PW-1:0]      rr_ptr_r;
  logic [NUM_REQ-1:0] grant_s;
  logic [PW-1:0]      grant_idx_s;
  logic               grant_any_s;
  logic [4:0]         sel_rd_s;
  logic [31:0]        sel_data_s;
  logic [31:0]        clr_mask_s;
  logic [31:0]        set_mask_s;

  // Round-robin search starting one past the last granted requester
  always_comb begin
    grant_s     = '0;
    grant_idx_s = rr_ptr_r;
    grant_any_s = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      grant_s[(int'(rr_ptr_r) + i) % NUM_REQ] =
        ~grant_any_s & req_valid[(int'(rr_ptr_r) + i) % NUM_REQ];
      grant_idx_s = (~grant_any_s & req_valid[(int'(rr_ptr_r) + i) % NUM_REQ])
                    ? PW'((int'(rr_ptr_r) + i) % NUM_REQ) : grant_idx_s;
      grant_any_s = grant_any_s | req_valid[(int'(rr_ptr_r) + i) % NUM_REQ];
    end
  end

  assign sel_rd_s   = req_rd[int'(grant_idx_s)*5 +: 5];
  assign sel_data_s = req_data[int'(grant_idx_s)*32 +: 32];
  assign req_ready  = grant_s;

  // Writeback register stage; a grant to x0 is consumed without raising the write enable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_r    <= PW'(NUM_REQ - 1);
      wb_rd_index <= 5'd0;
      wb_rd_data  <= 32'd0;
      wb_rd_we    <= 1'b0;
    end else if (grant_any_s) begin
      rr_ptr_r    <= grant_idx_s;
      wb_rd_index <= sel_rd_s;
      wb_rd_data  <= sel_data_s;
      wb_rd_we    <= (sel_rd_s != 5'd0);
    end else begin
      wb_rd_we    <= 1'b0;
    end
  end

  // Set is applied after clear so a same-index reservation keeps the register busy
  assign rsv_ready  = (rsv_rd == 5'd0) | ~busy_r[rsv_rd];
  assign clr_mask_s = wb_rd_we ? (32'd1 << wb_rd_index) : 32'd0;
  assign set_mask_s = (rsv_valid & rsv_ready & (rsv_rd != 5'd0)) ? (32'd1 << rsv_rd) : 32'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r <= 32'd0;
    end else if (sb_clear) begin
      busy_r <= 32'd0;
    end else begin
      busy_r <= (busy_r & ~clr_mask_s) | set_mask_s;
    end
  end

`ifdef WB_BYPASS_EN
  assign rs1_fwd_valid = wb_rd_we & (wb_rd_index == q_rs1) & (q_rs1 != 5'd0);
  assign rs2_fwd_valid = wb_rd_we & (wb_rd_index == q_rs2) & (q_rs2 != 5'd0);
  assign rs1_fwd_data  = rs1_fwd_valid ? wb_rd_data : 32'd0;
  assign rs2_fwd_data  = rs2_fwd_valid ? wb_rd_data : 32'd0;
`else
  assign rs1_fwd_valid = 1'b0;
  assign rs2_fwd_valid = 1'b0;
  assign rs1_fwd_data  = 32'd0;
  assign rs2_fwd_data  = 32'd0;
`endif

  assign rs1_hazard = busy_r[q_rs1] & ~rs1_fwd_valid & (q_rs1 != 5'd0);
  assign rs2_hazard = busy_r[q_rs2] & ~rs2_fwd_valid & (q_rs2 != 5'd0);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: vector table, directed corner sequences,
// and randomized traffic checked against a behavioural scoreboard model.
module tb_regfile_wb_arbiter;
  localparam int N = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N*5-1:0]  req_rd;
  logic [N*32-1:0] req_data;
  logic [N-1:0]  req_ready;
  logic          rsv_valid;
  logic [4:0]    rsv_rd;
  logic          rsv_ready;
  logic          sb_clear;
  logic [4:0]    q_rs1, q_rs2;
  logic          rs1_hazard, rs2_hazard, rs1_fwd_valid, rs2_fwd_valid;
  logic [31:0]   rs1_fwd_data, rs2_fwd_data;
  logic [4:0]    wb_rd_index;
  logic [31:0]   wb_rd_data;
  logic          wb_rd_we;

  regfile_wb_arbiter #(.NUM_REQ(N)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_rd(req_rd), .req_data(req_data),
    .req_ready(req_ready), .rsv_valid(rsv_valid), .rsv_rd(rsv_rd), .rsv_ready(rsv_ready),
    .sb_clear(sb_clear), .q_rs1(q_rs1), .q_rs2(q_rs2), .rs1_hazard(rs1_hazard),
    .rs2_hazard(rs2_hazard), .rs1_fwd_valid(rs1_fwd_valid), .rs1_fwd_data(rs1_fwd_data),
    .rs2_fwd_valid(rs2_fwd_valid), .rs2_fwd_data(rs2_fwd_data), .wb_rd_index(wb_rd_index),
    .wb_rd_data(wb_rd_data), .wb_rd_we(wb_rd_we)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // behavioural model state
  bit [31:0] m_busy;
  int        m_ptr;
  bit        m_we;
  bit [4:0]  m_idx;
  bit [31:0] m_data;

  // register file mirror, written on the falling edge like the real regfile
  logic [31:0] rf [32];
  always @(negedge clk) begin
    if (wb_rd_we) rf[wb_rd_index] <= wb_rd_data;
  end

  typedef struct {
    logic [2:0] valid;
    logic       rsv_v;
    logic [2:0] exp_ready;
    logic       exp_we;
    logic       exp_rsv_ready;
    logic       exp_haz1;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int m_grant();
    for (int k = 1; k <= N; k++) begin
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic void m_reset();
    m_busy = 32'd0; m_ptr = N - 1; m_we = 1'b0; m_idx = 5'd0; m_data = 32'd0;
  endfunction

  task automatic set_req(input int i, input logic [4:0] rd, input logic [31:0] d);
    req_rd[i*5 +: 5]    = rd;
    req_data[i*32 +: 32] = d;
  endtask

  // compare every output against the model, then advance one clock and the model
  task automatic step(input string tag);
    int g;
    logic [N-1:0] er;
    bit rr, f1, f2;
    #1;
    g  = m_grant();
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    rr = (rsv_rd == 5'd0) || !m_busy[rsv_rd];
`ifdef WB_BYPASS_EN
    f1 = m_we && (m_idx == q_rs1) && (q_rs1 != 5'd0);
    f2 = m_we && (m_idx == q_rs2) && (q_rs2 != 5'd0);
`else
    f1 = 1'b0;
    f2 = 1'b0;
`endif
    chk({tag, " req_ready"}, 32'(req_ready), 32'(er));
    chk({tag, " rsv_ready"}, 32'(rsv_ready), 32'(rr));
    chk({tag, " wb_rd_we"}, 32'(wb_rd_we), 32'(m_we));
    chk({tag, " wb_rd_index"}, 32'(wb_rd_index), 32'(m_idx));
    chk({tag, " wb_rd_data"}, wb_rd_data, m_data);
    chk({tag, " rs1_hazard"}, 32'(rs1_hazard), 32'(m_busy[q_rs1] && !f1 && q_rs1 != 5'd0));
    chk({tag, " rs2_hazard"}, 32'(rs2_hazard), 32'(m_busy[q_rs2] && !f2 && q_rs2 != 5'd0));
    chk({tag, " rs1_fwd_valid"}, 32'(rs1_fwd_valid), 32'(f1));
    chk({tag, " rs2_fwd_valid"}, 32'(rs2_fwd_valid), 32'(f2));
    chk({tag, " rs1_fwd_data"}, rs1_fwd_data, f1 ? m_data : 32'd0);
    chk({tag, " rs2_fwd_data"}, rs2_fwd_data, f2 ? m_data : 32'd0);
    @(posedge clk);
    if (sb_clear) m_busy = 32'd0;
    else begin
      if (m_we) m_busy[m_idx] = 1'b0;
      if (rsv_valid && rr && rsv_rd != 5'd0) m_busy[rsv_rd] = 1'b1;
    end
    if (g >= 0) begin
      m_ptr  = g;
      m_idx  = req_rd[g*5 +: 5];
      m_data = req_data[g*32 +: 32];
      m_we   = (m_idx != 5'd0);
    end else begin
      m_we = 1'b0;
    end
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = '0; rsv_valid = 1'b0; rsv_rd = 5'd0; sb_clear = 1'b0;
    q_rs1 = 5'd0; q_rs2 = 5'd0;
  endtask

  initial begin
    req_rd = '0; req_data = '0;
    idle_inputs();
    rst = 1'b1;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    // reset state, inputs all zero, still in reset
    chk("reset wb_rd_we", 32'(wb_rd_we), 32'd0);
    chk("reset req_ready", 32'(req_ready), 32'd0);
    chk("reset rsv_ready", 32'(rsv_ready), 32'd1);
    chk("reset rs1_hazard", 32'(rs1_hazard), 32'd0);
    chk("reset rs2_hazard", 32'(rs2_hazard), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // vector table: three requesters writing x1/x2/x3, reservation of x4 queried on rs1
    tbl[0] = '{3'b111, 1'b1, 3'b001, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{3'b111, 1'b1, 3'b010, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{3'b111, 1'b0, 3'b100, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{3'b111, 1'b0, 3'b001, 1'b1, 1'b0, 1'b1};
    tbl[4] = '{3'b010, 1'b0, 3'b010, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{3'b101, 1'b0, 3'b100, 1'b1, 1'b0, 1'b1};
    tbl[6] = '{3'b000, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1};
    tbl[7] = '{3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < N; i++) set_req(i, 5'(i + 1), 32'h1000_0000 + 32'(i));
    for (int v = 0; v < 8; v++) begin
      req_valid = tbl[v].valid; rsv_valid = tbl[v].rsv_v; rsv_rd = 5'd4; q_rs1 = 5'd4;
      #1;
      chk($sformatf("vec%0d ready", v), 32'(req_ready), 32'(tbl[v].exp_ready));
      chk($sformatf("vec%0d we", v), 32'(wb_rd_we), 32'(tbl[v].exp_we));
      chk($sformatf("vec%0d rsv_ready", v), 32'(rsv_ready), 32'(tbl[v].exp_rsv_ready));
      chk($sformatf("vec%0d haz1", v), 32'(rs1_hazard), 32'(tbl[v].exp_haz1));
      step($sformatf("vec%0d", v));
    end

    // busy x3/x9 then flush
    idle_inputs();
    rsv_valid = 1'b1; rsv_rd = 5'd3; step("rsv3");
    rsv_rd = 5'd9; step("rsv9");
    rsv_valid = 1'b0; q_rs1 = 5'd3; q_rs2 = 5'd9;
    #1; chk("pre-flush haz x3", 32'(rs1_hazard), 32'd1);
    sb_clear = 1'b1; step("flush");
    sb_clear = 1'b0;
    #1;
    chk("flush haz x3", 32'(rs1_hazard), 32'd0);
    chk("flush haz x9", 32'(rs2_hazard), 32'd0);
    step("post-flush");

    // reserve x5, requester 1 writes DEADBEEF
    idle_inputs();
    rsv_valid = 1'b1; rsv_rd = 5'd5; step("rsv5");
    rsv_valid = 1'b0; q_rs1 = 5'd5;
    set_req(1, 5'd5, 32'hDEAD_BEEF); req_valid = 3'b010;
    #1; chk("x5 haz t", 32'(rs1_hazard), 32'd1);
    step("x5 t");
    req_valid = '0;
    #1;
`ifdef WB_BYPASS_EN
    chk("x5 haz t+1", 32'(rs1_hazard), 32'd0);
    chk("x5 fwd t+1", rs1_fwd_data, 32'hDEAD_BEEF);
`else
    chk("x5 haz t+1", 32'(rs1_hazard), 32'd1);
`endif
    step("x5 t+1");
    #1;
    chk("x5 haz t+2", 32'(rs1_hazard), 32'd0);
    chk("regfile x5", rf[5], 32'hDEAD_BEEF);
    step("x5 t+2");

    // re-reserve x7 while its write is in flight
    rsv_valid = 1'b1; rsv_rd = 5'd7; step("rsv7");
    rsv_valid = 1'b0; set_req(0, 5'd7, 32'h0000_7777); req_valid = 3'b001; step("x7 t");
    req_valid = '0; rsv_valid = 1'b1; q_rs2 = 5'd7;
    #1; chk("x7 rsv_ready in flight", 32'(rsv_ready), 32'd0);
    step("x7 t+1");
    #1; chk("x7 rsv_ready after", 32'(rsv_ready), 32'd1);
    step("x7 t+2");
    rsv_valid = 1'b0;
    #1; chk("x7 busy again", 32'(rs2_hazard), 32'd1);
    step("x7 t+3");

    // write to x0 and reserve x0
    set_req(2, 5'd0, 32'h0000_1234); req_valid = 3'b100; q_rs1 = 5'd0;
    rsv_valid = 1'b1; rsv_rd = 5'd0;
    #1; chk("x0 ready", 32'(req_ready), 32'b100);
    step("x0 t");
    req_valid = '0; rsv_valid = 1'b0;
    #1;
    chk("x0 we", 32'(wb_rd_we), 32'd0);
    chk("x0 rsv_ready", 32'(rsv_ready), 32'd1);
    chk("x0 haz", 32'(rs1_hazard), 32'd0);
    step("x0 t+1");

    // asynchronous reset while a write is in flight
    set_req(0, 5'd6, 32'h0000_6666); req_valid = 3'b001; step("rst t");
    req_valid = '0;
    #1; chk("pre-rst we", 32'(wb_rd_we), 32'd1);
    rst = 1'b1;
    #1; chk("rst drops we", 32'(wb_rd_we), 32'd0);
    m_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    idle_inputs();

    // randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      req_valid = N'($urandom);
      for (int i = 0; i < N; i++) set_req(i, 5'($urandom), $urandom);
      rsv_valid = 1'($urandom);
      rsv_rd    = 5'($urandom_range(0, 11));
      q_rs1     = 5'($urandom_range(0, 11));
      q_rs2     = 5'($urandom_range(0, 11));
      sb_clear  = ($urandom_range(0, 15) == 0);
      step($sformatf("rand%0d", c));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
